// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and key codes for the keypad scanner
package keypad_pkg;

   localparam int KEY_W = 4;
   localparam int COLS  = 4;
   localparam int ROWS  = 4;

   typedef enum logic [2:0] {
      SCAN    = 3'd0,
      CONFIRM = 3'd1,
      ACCEPT  = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   // Key code = {col_idx, row_idx}; layout of the microwave panel
   localparam logic [KEY_W-1:0] KEY_1     = 4'h0;
   localparam logic [KEY_W-1:0] KEY_4     = 4'h1;
   localparam logic [KEY_W-1:0] KEY_7     = 4'h2;
   localparam logic [KEY_W-1:0] KEY_START = 4'h3;
   localparam logic [KEY_W-1:0] KEY_2     = 4'h4;
   localparam logic [KEY_W-1:0] KEY_5     = 4'h5;
   localparam logic [KEY_W-1:0] KEY_8     = 4'h6;
   localparam logic [KEY_W-1:0] KEY_0     = 4'h7;
   localparam logic [KEY_W-1:0] KEY_3     = 4'h8;
   localparam logic [KEY_W-1:0] KEY_6     = 4'h9;
   localparam logic [KEY_W-1:0] KEY_9     = 4'hA;
   localparam logic [KEY_W-1:0] KEY_STOP  = 4'hB;

   // Lowest set row index wins; returns 0 when no row is set
   function automatic logic [1:0] lowest_row(input logic [ROWS-1:0] rows);
      logic [1:0] r;
      r = 2'd0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (rows[i]) r = 2'(i);
      end
      return r;
   endfunction

   // One-hot column drive for a column index
   function automatic logic [COLS-1:0] col_onehot(input logic [1:0] col);
      return 4'b0001 << col;
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_timer.sv
// rtl/keypad_scan_ctrl_scan_timer.sv - free-running dwell counter producing the row sample tick
module scan_timer #(
   parameter int SCAN_DIV = 4
) (
   input  logic clock,
   input  logic clearn,
   input  logic enable,
   output logic tick
);

   localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

   logic [7:0] dwell_q;
   logic [7:0] dwell_d;

   // Next dwell count: parked at 0 while disabled, wraps after the last dwell cycle
   always_comb begin
      dwell_d = dwell_q;
      if (!enable) begin
         dwell_d = 8'd0;
      end else if (dwell_q == DIV_LAST) begin
         dwell_d = 8'd0;
      end else begin
         dwell_d = dwell_q + 8'd1;
      end
   end

   // Dwell counter register
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         dwell_q <= 8'd0;
      end else begin
         dwell_q <= dwell_d;
      end
   end

   // Rows are sampled on the edge that ends the dwell
   assign tick = enable && (dwell_q == DIV_LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic             clock,
   input  logic             clearn,
   input  logic             enable,
   input  logic [ROWS-1:0]  row_in,
   output logic [COLS-1:0]  col_out,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held
);

   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE);

   logic             tick;
   state_t           state_q;
   logic [1:0]       col_idx_q;
   logic [1:0]       row_idx_q;
   logic [3:0]       deb_cnt_q;
   logic [COLS-1:0]  col_out_q;
   logic [KEY_W-1:0] key_code_q;
   logic             key_valid_q;
   logic             key_held_q;

   logic [1:0]       row_low;
   logic             row_any;
   logic             row_bit;
   logic             cand_ok;
   logic [1:0]       col_next;
   logic [3:0]       deb_inc;

   scan_timer #(
      .SCAN_DIV(SCAN_DIV)
   ) u_scan_timer (
      .clock  (clock),
      .clearn (clearn),
      .enable (enable),
      .tick   (tick)
   );

   // Row priority encode and debounce helpers
   always_comb begin
      row_low  = lowest_row(row_in);
      row_any  = |row_in;
      row_bit  = row_in[row_idx_q];
      cand_ok  = row_bit && (row_low == row_idx_q);
      col_next = col_idx_q + 2'd1;
      deb_inc  = deb_cnt_q + 4'd1;
   end

   // Scan / debounce / accept sequencer with registered outputs
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         deb_cnt_q   <= 4'd0;
         col_out_q   <= 4'b0001;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else if (!enable) begin
         state_q     <= SCAN;
         deb_cnt_q   <= 4'd0;
         col_out_q   <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         // Restores the drive after a re-enable; rotation below overrides it
         col_out_q   <= col_onehot(col_idx_q);
         case (state_q)
            SCAN: begin
               if (tick) begin
                  if (row_any) begin
                     row_idx_q <= row_low;
                     deb_cnt_q <= 4'd1;
                     if (DEBOUNCE == 1) begin
                        // key_code is loaded together with the pulse so both are valid in ACCEPT
                        state_q     <= ACCEPT;
                        key_valid_q <= 1'b1;
                        key_code_q  <= {col_idx_q, row_low};
                     end else begin
                        state_q <= CONFIRM;
                     end
                  end else begin
                     col_idx_q <= col_next;
                     col_out_q <= col_onehot(col_next);
                  end
               end
            end
            CONFIRM: begin
               if (tick) begin
                  if (cand_ok) begin
                     deb_cnt_q <= deb_inc;
                     if (deb_inc == DEB_LAST) begin
                        state_q     <= ACCEPT;
                        key_valid_q <= 1'b1;
                        key_code_q  <= {col_idx_q, row_idx_q};
                     end
                  end else begin
                     // Lost or displaced candidate: resume at the next column
                     state_q   <= SCAN;
                     deb_cnt_q <= 4'd0;
                     col_idx_q <= col_next;
                     col_out_q <= col_onehot(col_next);
                  end
               end
            end
            ACCEPT: begin
               state_q    <= HOLD;
               deb_cnt_q  <= 4'd0;
               key_held_q <= 1'b1;
            end
            HOLD: begin
               if (tick && !row_bit) begin
                  if (DEBOUNCE == 1) begin
                     state_q    <= SCAN;
                     deb_cnt_q  <= 4'd0;
                     key_held_q <= 1'b0;
                     col_idx_q  <= col_next;
                     col_out_q  <= col_onehot(col_next);
                  end else begin
                     state_q   <= RELEASE;
                     deb_cnt_q <= 4'd1;
                  end
               end
            end
            RELEASE: begin
               if (tick) begin
                  if (!row_bit) begin
                     deb_cnt_q <= deb_inc;
                     if (deb_inc == DEB_LAST) begin
                        state_q    <= SCAN;
                        deb_cnt_q  <= 4'd0;
                        key_held_q <= 1'b0;
                        col_idx_q  <= col_next;
                        col_out_q  <= col_onehot(col_next);
                     end
                  end else begin
                     // Release bounce: back to HOLD without a new pulse
                     state_q   <= HOLD;
                     deb_cnt_q <= 4'd0;
                  end
               end
            end
            default: begin
               state_q   <= SCAN;
               deb_cnt_q <= 4'd0;
            end
         endcase
      end
   end

   assign col_out   = col_out_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

   logic       clock;
   logic       clearn;
   logic       enable;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] keys [4];
   int         total;
   int         bad;
   int         pulses;

   keypad_scan_ctrl #(
      .SCAN_DIV(4),
      .DEBOUNCE(3)
   ) dut (
      .clock     (clock),
      .clearn    (clearn),
      .enable    (enable),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Key matrix: a pressed key connects its column drive to its row
   always_comb begin
      row_in = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         if (col_out[c]) row_in = row_in | keys[c];
      end
   end

   always @(negedge clock) begin
      if (key_valid === 1'b1) pulses++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      clearn = 1'b0;
      cyc(2);
      clearn = 1'b1;
      pulses = 0;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      pulses = 0;
      enable = 1'b1;
      clearn = 1'b0;
      for (int c = 0; c < 4; c++) keys[c] = 4'b0000;

      // 1. reset state and idle rotation
      cyc(2);
      check("rst_col", 8'(col_out), 8'h01);
      check("rst_code", 8'(key_code), 8'h0);
      check("rst_valid", 8'(key_valid), 8'h0);
      check("rst_held", 8'(key_held), 8'h0);
      clearn = 1'b1;
      pulses = 0;
      cyc(3);
      check("idle_e3", 8'(col_out), 8'h01);
      cyc(1);
      check("idle_e4", 8'(col_out), 8'h02);
      cyc(4);
      check("idle_e8", 8'(col_out), 8'h04);
      cyc(4);
      check("idle_e12", 8'(col_out), 8'h08);
      cyc(4);
      check("idle_wrap", 8'(col_out), 8'h01);
      check("idle_nopulse", 8'(pulses), 8'd0);

      // 2. clean press col 0 / row 2, then 4. release bounce
      keys[0] = 4'b0100;
      do_reset();
      cyc(4);
      check("press_col_held", 8'(col_out), 8'h01);
      cyc(7);
      check("press_e11_valid", 8'(key_valid), 8'h0);
      cyc(1);
      check("press_valid", 8'(key_valid), 8'h1);
      check("press_code", 8'(key_code), 8'h2);
      cyc(1);
      check("press_pulse_end", 8'(key_valid), 8'h0);
      check("press_held", 8'(key_held), 8'h1);
      keys[0] = 4'b0000;
      cyc(3);
      check("relb_held1", 8'(key_held), 8'h1);
      keys[0] = 4'b0100;
      cyc(4);
      check("relb_held2", 8'(key_held), 8'h1);
      keys[0] = 4'b0000;
      cyc(11);
      check("rel_e31_held", 8'(key_held), 8'h1);
      cyc(1);
      check("rel_held_drop", 8'(key_held), 8'h0);
      check("rel_next_col", 8'(col_out), 8'h02);
      check("rel_one_pulse", 8'(pulses), 8'd1);

      // 3. press bounce at col 2 / row 1
      for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
      keys[2] = 4'b0010;
      do_reset();
      cyc(16);
      keys[2] = 4'b0000;
      cyc(4);
      check("bnc_resume_col3", 8'(col_out), 8'h08);
      check("bnc_no_pulse", 8'(pulses), 8'd0);
      keys[2] = 4'b0010;
      cyc(23);
      check("bnc_e43_valid", 8'(key_valid), 8'h0);
      cyc(1);
      check("bnc_valid", 8'(key_valid), 8'h1);
      check("bnc_code", 8'(key_code), 8'h9);
      cyc(1);
      check("bnc_held", 8'(key_held), 8'h1);
      check("bnc_one_pulse", 8'(pulses), 8'd1);

      // 5. multi-key on col 3 and wrap after release
      for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
      keys[3] = 4'b1010;
      do_reset();
      cyc(24);
      check("multi_valid", 8'(key_valid), 8'h1);
      check("multi_code", 8'(key_code), 8'hD);
      keys[3] = 4'b0000;
      cyc(12);
      check("multi_held_drop", 8'(key_held), 8'h0);
      check("multi_wrap_col0", 8'(col_out), 8'h01);

      // 6a. disable during CONFIRM on col 1 / row 0
      keys[1] = 4'b0001;
      cyc(8);
      check("dis_confirm_col", 8'(col_out), 8'h02);
      enable = 1'b0;
      cyc(1);
      check("dis_col", 8'(col_out), 8'h00);
      check("dis_code_kept", 8'(key_code), 8'hD);
      check("dis_held", 8'(key_held), 8'h0);
      cyc(8);
      check("dis_col_parked", 8'(col_out), 8'h00);
      check("dis_no_pulse", 8'(pulses), 8'd1);
      enable = 1'b1;
      cyc(1);
      check("reen_col", 8'(col_out), 8'h02);
      cyc(10);
      check("reen_e11_valid", 8'(key_valid), 8'h0);
      cyc(1);
      check("reen_valid", 8'(key_valid), 8'h1);
      check("reen_code", 8'(key_code), 8'h4);
      cyc(1);
      check("reen_held", 8'(key_held), 8'h1);

      // 6b. asynchronous reset during HOLD
      clearn = 1'b0;
      #1;
      check("arst_col", 8'(col_out), 8'h01);
      check("arst_code", 8'(key_code), 8'h0);
      check("arst_valid", 8'(key_valid), 8'h0);
      check("arst_held", 8'(key_held), 8'h0);
      for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
      cyc(2);
      clearn = 1'b1;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
